rc4_decrypt_core: RTL and testbench
===================================

Name: rc4_decrypt_core

Overview:
- Responder side of the brute-force search handshake: on each start pulse it latches a 22-bit candidate key and runs full RC4 (KSA + PRGA) over a 32-byte ciphertext ROM.
- It writes the plaintext to a decrypted-message RAM and checks every byte.
- It reports completion on finish plus a pass/fail on valid; the search controller drives start/key and consumes finish/valid.
- One instance per core; the controller steps keys by core_count.

Parameters:
- MSG_LEN, 32, ciphertext/plaintext length in bytes (address width clog2(MSG_LEN)=5).
- KEY_BYTES, 3, RC4 key length in bytes; key byte order is {2'b00,key[21:16]}, key[15:8], key[7:0].

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: abort any run, latch key, begin a new run.
- key  in  22  candidate key; sampled only on the first cycle of a run.
- s_addr  out  8  S-box RAM address.
- s_wdata  out  8  S-box write data.
- s_wren  out  1  S-box write enable.
- s_rdata  in  8  S-box read data.
- rom_addr  out  5  ciphertext ROM address.
- rom_rdata  in  8  ciphertext byte.
- dram_addr  out  5  decrypted RAM address.
- dram_wdata  out  8  plaintext byte.
- dram_wren  out  1  decrypted RAM write enable.
- finish  out  1  run done; level, held until the next run starts.
- valid  out  1  qualified by finish: 1 means all MSG_LEN bytes passed the check.

Behaviour:
- Reset: all outputs 0; i=j=k=0.
  - After rst deasserts, a run starts automatically on the first clk edge, with key sampled that cycle. This matches the controller, which waits on finish after reset without pulsing.
- Memory timing: S RAM and ROM read data is valid the cycle after the address is presented. The FSM inserts one WAIT state per read. Writes take effect at the edge where wren=1.
- FSM states:
  - INIT: S[i]=i for i=0..255, one write per cycle (256 cycles), then KSA with i=0, j=0.
  - KSA_RD_I → KSA_WT_I: capture si=S[i]; j=j+si+keybyte[i mod KEY_BYTES], all mod 256.
  - KSA_RD_J → KSA_WT_J: capture sj=S[j].
  - KSA_WR_I: S[i]=sj.
  - KSA_WR_J: S[j]=si.
  - After KSA_WR_J: i++; when i wraps from 255 go to PRGA with i=0, j=0, k=0. i mod 3 uses a 0..2 counter, not a divider.
  - PRGA per byte k:
    - i=i+1; read S[i] → si.
    - j=j+si; read S[j] → sj.
    - Write S[i]=sj, then S[j]=si.
    - Read S[si+sj] → f, with ROM[k] read in the same cycle.
    - WRITE_OUT: dram_wdata = f ^ rom_rdata, dram_wren=1, dram_addr=k.
  - CHECK:
    - Byte valid iff 8'h61..8'h7A or 8'h20.
    - Invalid byte → DONE with valid=0 (early abort; remaining bytes are not written).
    - Valid byte with k==MSG_LEN-1 → DONE with valid=1.
    - Otherwise k++, next byte.
  - DONE: finish=1, valid held; stays in DONE until start.
- Cycle budget: full valid run ≤ 256 + 256*6 + MSG_LEN*10 + 4 cycles (about 2150); early abort is strictly shorter.
- start semantics:
  - From any state, including mid-KSA and mid-PRGA, start forces INIT on the next edge with i=j=k=0 and the new key latched.
  - finish and valid clear on that same edge.
  - The S RAM is not trusted; INIT rewrites it fully.
- start held for more than one cycle: the run restarts each cycle; only the last cycle counts.
- Simultaneous start and final CHECK: start wins; finish is never asserted for the old key.
- All index arithmetic is 8-bit wrap-around; k is 5 bits, and k == MSG_LEN-1 is the terminal compare.
- rst mid-run: asynchronous clear to reset values. The run restarts after deassertion and overwrites S; no memory clear is needed.
- Outside write states, wren=0; address outputs are don't-care but registered (no glitches).

Decomposition:
- rc4_pkg holds:
  - the state enum;
  - MSG_LEN, KEY_BYTES, CHAR_A=8'h61, CHAR_Z=8'h7A, CHAR_SP=8'h20;
  - function is_valid_char(byte).
- Single module, no sub-module. KSA and PRGA share the S port and the swap sequence, so splitting them would duplicate arbitration.

Test Plan:
- Reset, key=22'h000000, ROM = RC4(key {00,00,00}) of "the quick brown fox jumps over t" → finish=1 within 2150 cycles, valid=1, dram holds the 32 plaintext bytes.
- Same ROM, key=22'h000001 → finish=1, valid=0, early abort: fewer than MSG_LEN dram writes, total cycles < full-run count.
- ROM whose byte 31 decrypts to 8'h7B ('{') under the correct key → valid=0 only after 31 good writes; bytes 8'h61, 8'h7A, 8'h20 alone → accepted.
- start pulse mid-KSA (cycle 900) with key=22'h3FFFFF → no finish for the old key; new run completes; result matches the reference model for {00,3F,FF}... key bytes {8'h3F,8'hFF,8'hFF}.
- In DONE with finish=1, pulse start with the correct key → finish=0 and valid=0 next cycle, then finish=1, valid=1 after the full run.
- Assert rst during PRGA byte 10 → all outputs 0 asynchronously; after release, a new run with the current key produces a correct result.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 candidate-key decryption core.
package rc4_pkg;

   localparam int MSG_LEN   = 32;
   localparam int KEY_BYTES = 3;
   localparam int ADDR_W    = $clog2(MSG_LEN);

   localparam logic [7:0] CHAR_A  = 8'h61;
   localparam logic [7:0] CHAR_Z  = 8'h7A;
   localparam logic [7:0] CHAR_SP = 8'h20;

   typedef enum logic [4:0] {
      ST_LOAD,
      ST_INIT,
      ST_KSA_RD_I,
      ST_KSA_WT_I,
      ST_KSA_RD_J,
      ST_KSA_WT_J,
      ST_KSA_WR_I,
      ST_KSA_WR_J,
      ST_PRGA_RD_I,
      ST_PRGA_WT_I,
      ST_PRGA_RD_J,
      ST_PRGA_WT_J,
      ST_PRGA_WR_I,
      ST_PRGA_WR_J,
      ST_PRGA_RD_F,
      ST_PRGA_WT_F,
      ST_WRITE_OUT,
      ST_CHECK,
      ST_DONE
   } rc4_state_e;

   // Plaintext is accepted only if it is lowercase ASCII or a space.
   function automatic logic is_valid_char(input logic [7:0] b);
      return ((b >= CHAR_A) && (b <= CHAR_Z)) || (b == CHAR_SP);
   endfunction

endpackage

// File: rtl/rc4_decrypt_core.sv
// RC4 (KSA + PRGA) decryption of a ciphertext ROM under a latched candidate key,
// with per-byte plaintext check and a finish/valid result for the search controller.
module rc4_decrypt_core
   import rc4_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   // Handshake: a one-cycle start aborts any run and latches key; finish is a
   // level held until the next start, and valid is meaningful only while finish=1.
   input  logic              start,
   input  logic [21:0]       key,
   output logic [7:0]        s_addr,
   output logic [7:0]        s_wdata,
   output logic              s_wren,
   input  logic [7:0]        s_rdata,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_rdata,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [7:0]        dram_wdata,
   output logic              dram_wren,
   output logic              finish,
   output logic              valid,
   output rc4_state_e        dbg_state
);

   rc4_state_e        state, state_n;
   logic [21:0]       key_q, key_n;
   logic [7:0]        i, i_n, j, j_n, si, si_n, sj, sj_n;
   logic [ADDR_W-1:0] k, k_n;
   logic [1:0]        kc, kc_n;
   logic [7:0]        key_byte;

   logic [7:0]        s_addr_n, s_wdata_n, dram_wdata_n;
   logic              s_wren_n, dram_wren_n, finish_n, valid_n;
   logic [ADDR_W-1:0] rom_addr_n, dram_addr_n;

   assign dbg_state = state;

   always_comb begin
      case (kc)
         2'd0:    key_byte = {2'b00, key_q[21:16]};
         2'd1:    key_byte = key_q[15:8];
         default: key_byte = key_q[7:0];
      endcase
   end

   always_comb begin
      state_n      = state;
      key_n        = key_q;
      i_n          = i;
      j_n          = j;
      k_n          = k;
      kc_n         = kc;
      si_n         = si;
      sj_n         = sj;
      s_addr_n     = s_addr;
      s_wdata_n    = s_wdata;
      s_wren_n     = 1'b0;
      rom_addr_n   = rom_addr;
      dram_addr_n  = dram_addr;
      dram_wdata_n = dram_wdata;
      dram_wren_n  = 1'b0;
      finish_n     = finish;
      valid_n      = valid;

      if (start || state == ST_LOAD) begin
         state_n  = ST_INIT;
         key_n    = key;
         i_n      = 8'd0;
         j_n      = 8'd0;
         k_n      = '0;
         kc_n     = 2'd0;
         finish_n = 1'b0;
         valid_n  = 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               if (i == 8'hFF) begin
                  state_n = ST_KSA_RD_I;
                  i_n     = 8'd0;
                  j_n     = 8'd0;
                  kc_n    = 2'd0;
               end else begin
                  i_n = i + 8'd1;
               end
            end
            ST_KSA_RD_I: state_n = ST_KSA_WT_I;
            ST_KSA_WT_I: begin
               si_n    = s_rdata;
               j_n     = j + s_rdata + key_byte;
               state_n = ST_KSA_RD_J;
            end
            ST_KSA_RD_J: state_n = ST_KSA_WT_J;
            ST_KSA_WT_J: begin
               sj_n    = s_rdata;
               state_n = ST_KSA_WR_I;
            end
            ST_KSA_WR_I: state_n = ST_KSA_WR_J;
            ST_KSA_WR_J: begin
               kc_n = (kc == 2'(KEY_BYTES - 1)) ? 2'd0 : kc + 2'd1;
               if (i == 8'hFF) begin
                  // PRGA pre-increments i, so its first byte reads S[1].
                  state_n = ST_PRGA_RD_I;
                  i_n     = 8'd1;
                  j_n     = 8'd0;
                  k_n     = '0;
               end else begin
                  state_n = ST_KSA_RD_I;
                  i_n     = i + 8'd1;
               end
            end
            ST_PRGA_RD_I: state_n = ST_PRGA_WT_I;
            ST_PRGA_WT_I: begin
               si_n    = s_rdata;
               j_n     = j + s_rdata;
               state_n = ST_PRGA_RD_J;
            end
            ST_PRGA_RD_J: state_n = ST_PRGA_WT_J;
            ST_PRGA_WT_J: begin
               sj_n    = s_rdata;
               state_n = ST_PRGA_WR_I;
            end
            ST_PRGA_WR_I: state_n = ST_PRGA_WR_J;
            ST_PRGA_WR_J: state_n = ST_PRGA_RD_F;
            ST_PRGA_RD_F: state_n = ST_PRGA_WT_F;
            ST_PRGA_WT_F: begin
               dram_wdata_n = s_rdata ^ rom_rdata;
               state_n      = ST_WRITE_OUT;
            end
            ST_WRITE_OUT: state_n = ST_CHECK;
            ST_CHECK: begin
               if (!is_valid_char(dram_wdata)) begin
                  state_n  = ST_DONE;
                  finish_n = 1'b1;
                  valid_n  = 1'b0;
               end else if (k == ADDR_W'(MSG_LEN - 1)) begin
                  state_n  = ST_DONE;
                  finish_n = 1'b1;
                  valid_n  = 1'b1;
               end else begin
                  state_n = ST_PRGA_RD_I;
                  i_n     = i + 8'd1;
                  k_n     = k + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end

      // Memory-side outputs are decoded from the state being entered so they
      // come straight out of flops during that state.
      case (state_n)
         ST_INIT: begin
            s_addr_n  = i_n;
            s_wdata_n = i_n;
            s_wren_n  = 1'b1;
         end
         ST_KSA_RD_I, ST_PRGA_RD_I: s_addr_n = i_n;
         ST_KSA_RD_J, ST_PRGA_RD_J: s_addr_n = j_n;
         ST_KSA_WR_I, ST_PRGA_WR_I: begin
            s_addr_n  = i_n;
            s_wdata_n = sj_n;
            s_wren_n  = 1'b1;
         end
         ST_KSA_WR_J, ST_PRGA_WR_J: begin
            s_addr_n  = j_n;
            s_wdata_n = si_n;
            s_wren_n  = 1'b1;
         end
         ST_PRGA_RD_F: begin
            s_addr_n   = si_n + sj_n;
            rom_addr_n = k_n;
         end
         ST_WRITE_OUT: begin
            dram_addr_n = k_n;
            dram_wren_n = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_LOAD;
         key_q      <= '0;
         i          <= '0;
         j          <= '0;
         k          <= '0;
         kc         <= '0;
         si         <= '0;
         sj         <= '0;
         s_addr     <= '0;
         s_wdata    <= '0;
         s_wren     <= 1'b0;
         rom_addr   <= '0;
         dram_addr  <= '0;
         dram_wdata <= '0;
         dram_wren  <= 1'b0;
         finish     <= 1'b0;
         valid      <= 1'b0;
      end else begin
         state      <= state_n;
         key_q      <= key_n;
         i          <= i_n;
         j          <= j_n;
         k          <= k_n;
         kc         <= kc_n;
         si         <= si_n;
         sj         <= sj_n;
         s_addr     <= s_addr_n;
         s_wdata    <= s_wdata_n;
         s_wren     <= s_wren_n;
         rom_addr   <= rom_addr_n;
         dram_addr  <= dram_addr_n;
         dram_wdata <= dram_wdata_n;
         dram_wren  <= dram_wren_n;
         finish     <= finish_n;
         valid      <= valid_n;
      end
   end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Bench for rc4_decrypt_core: memory models, an RC4 reference computed directly
// from the algorithm, and a scoreboard of expected decrypted-RAM writes.
module tb_rc4_decrypt_core;
   import rc4_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [21:0] key_in;
   logic [7:0]  s_addr, s_wdata, s_rdata;
   logic        s_wren;
   logic [4:0]  rom_addr, dram_addr;
   logic [7:0]  rom_rdata, dram_wdata;
   logic        dram_wren, finish, valid;
   rc4_state_e  dbg_state;

   logic [7:0]  s_mem[256];
   logic [7:0]  rom[32];
   logic [7:0]  dram_img[32];
   logic [7:0]  pt_b[32];
   logic [7:0]  ks_m[32];

   logic [12:0] exp_q[$];
   logic [12:0] e;
   logic        exp_valid;
   int          exp_nwr;
   int          n_wr;
   int          total = 0;
   int          bad = 0;
   int          cyc, cyc_full;
   logic [21:0] kr;

   logic [7:0] b31_c[6] = '{8'h7B, 8'h61, 8'h7A, 8'h20, 8'h60, 8'h21};
   logic       b31_v[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   rc4_decrypt_core dut (
      .clk(clk), .rst(rst), .start(start), .key(key_in),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
      .rom_addr(rom_addr), .rom_rdata(rom_rdata),
      .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_wren(dram_wren),
      .finish(finish), .valid(valid), .dbg_state(dbg_state)
   );

   // ---------------- clock / memories ----------------
   always #5 clk = ~clk;

   // S RAM contents are scrambled while start is high so INIT must rebuild them.
   always @(posedge clk) begin
      if (start) begin
         for (int a = 0; a < 256; a++) s_mem[a] <= 8'($urandom);
      end else if (s_wren) begin
         s_mem[s_addr] <= s_wdata;
      end
      s_rdata   <= s_mem[s_addr];
      rom_rdata <= rom[rom_addr];
      if (dram_wren) dram_img[dram_addr] <= dram_wdata;
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
      end
   endtask

   function automatic logic char_ok(input logic [7:0] b);
      return (b inside {[8'h61:8'h7A]}) || (b == 8'h20);
   endfunction

   task automatic rc4_keystream(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] s[256];
      logic [7:0] kb[3];
      logic [7:0] t;
      int ii, jj;
      kb[0] = b0; kb[1] = b1; kb[2] = b2;
      for (int a = 0; a < 256; a++) s[a] = 8'(a);
      jj = 0;
      for (int a = 0; a < 256; a++) begin
         jj = (jj + int'(s[a]) + int'(kb[a % 3])) % 256;
         t = s[a]; s[a] = s[jj]; s[jj] = t;
      end
      ii = 0; jj = 0;
      for (int n = 0; n < 32; n++) begin
         ii = (ii + 1) % 256;
         jj = (jj + int'(s[ii])) % 256;
         t = s[ii]; s[ii] = s[jj]; s[jj] = t;
         ks_m[n] = s[(int'(s[ii]) + int'(s[jj])) % 256];
      end
   endtask

   task automatic key_stream(input logic [21:0] k);
      rc4_keystream({2'b00, k[21:16]}, k[15:8], k[7:0]);
   endtask

   task automatic set_msg(input string m);
      for (int n = 0; n < 32; n++) pt_b[n] = m[n];
   endtask

   task automatic rand_msg();
      int r;
      for (int n = 0; n < 32; n++) begin
         r = $urandom_range(0, 26);
         pt_b[n] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      end
   endtask

   task automatic make_rom(input logic [21:0] k);
      key_stream(k);
      for (int n = 0; n < 32; n++) rom[n] = pt_b[n] ^ ks_m[n];
   endtask

   // Expected write sequence: every byte up to and including the first bad one.
   task automatic load_model(input logic [21:0] k);
      logic [7:0] p;
      key_stream(k);
      exp_q.delete();
      n_wr = 0;
      exp_nwr = 0;
      exp_valid = 1'b1;
      for (int n = 0; n < 32; n++) begin
         p = rom[n] ^ ks_m[n];
         exp_q.push_back({5'(n), p});
         exp_nwr++;
         if (!char_ok(p)) begin
            exp_valid = 1'b0;
            break;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input logic [21:0] k, input int hold);
      @(posedge clk); #2;
      start = 1'b1;
      for (int c = 1; c < hold; c++) begin
         key_in = 22'($urandom);
         @(posedge clk); #2;
      end
      key_in = k;
      @(posedge clk); #1;
      load_model(k);
      #1 start = 1'b0;
   endtask

   task automatic check_done(input string nm, output int cycles);
      cycles = 0;
      while (finish !== 1'b1 && cycles < 2150) begin
         @(posedge clk); #1;
         cycles++;
      end
      chk({nm, "_finish"}, 64'(finish), 64'd1);
      chk({nm, "_valid"}, 64'(valid), 64'(exp_valid));
      chk({nm, "_nwrites"}, 64'(n_wr), 64'(exp_nwr));
      chk({nm, "_leftover"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, {s_addr, s_wdata, s_wren, rom_addr, dram_addr, dram_wdata,
               dram_wren, finish, valid}, 64'd0);
   endtask

   // ---------------- scoreboard / compare process ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (dram_wren) begin
            n_wr++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL dram_extra: got addr=%0h data=%0h want no write", dram_addr, dram_wdata);
            end else begin
               e = exp_q.pop_front();
               total--;
               chk("dram_write", 64'({dram_addr, dram_wdata}), 64'(e));
            end
         end
         if (exp_q.size() != 0) chk("finish_early", 64'(finish), 64'd0);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      start = 1'b0;
      key_in = 22'h000000;
      exp_q.delete();
      n_wr = 0;

      // Pin the reference model with the published RC4 vector for key "Key".
      rc4_keystream(8'h4B, 8'h65, 8'h79);
      chk("model_ks0", 64'(ks_m[0]), 64'hEB);
      chk("model_ks1", 64'(ks_m[1]), 64'h9F);
      chk("model_ks2", 64'(ks_m[2]), 64'h77);
      chk("model_ks3", 64'(ks_m[3]), 64'h81);
      chk("model_ks4", 64'(ks_m[4]), 64'hB7);

      set_msg("the quick brown fox jumps over t");
      make_rom(22'h000000);

      repeat (3) @(posedge clk);
      #1 chk_zero("reset_outputs");
      chk("reset_dbg", 64'(dbg_state), 64'(ST_LOAD));

      // Run starts automatically after reset release with the key present then.
      #1 rst = 1'b0;
      load_model(key_in);
      check_done("auto_run", cyc);
      chk("auto_run_budget", 64'(cyc <= 2150), 64'd1);
      for (int n = 0; n < 32; n++) chk("auto_run_dram", 64'(dram_img[n]), 64'(pt_b[n]));
      repeat (5) @(posedge clk);
      #1 chk("finish_held", 64'({finish, valid}), 64'b11);

      // Restart from DONE: result clears on the start edge.
      pulse_start(22'h000000, 1);
      chk("restart_clear", 64'({finish, valid}), 64'b00);
      check_done("restart", cyc_full);

      // Wrong key: early abort.
      pulse_start(22'h000001, 1);
      check_done("wrong_key", cyc);
      chk("wrong_key_short", 64'(cyc < cyc_full), 64'd1);
      chk("wrong_key_partial", 64'(n_wr < 32), 64'd1);

      // Last-byte boundary characters.
      for (int c = 0; c < 6; c++) begin
         set_msg("the quick brown fox jumps over t");
         pt_b[31] = b31_c[c];
         make_rom(22'h000000);
         pulse_start(22'h000000, 1);
         check_done("byte31", cyc);
         chk("byte31_valid_lit", 64'(valid), 64'(b31_v[c]));
         chk("byte31_writes", 64'(n_wr), 64'd32);
      end

      // start mid-KSA with a new key.
      set_msg("the quick brown fox jumps over t");
      make_rom(22'h000000);
      pulse_start(22'h000000, 1);
      repeat (900) @(posedge clk);
      #1 chk("mid_ksa_no_finish", 64'(finish), 64'd0);
      pulse_start(22'h3FFFFF, 1);
      check_done("mid_ksa", cyc);

      // Held start with random keys; only the last cycle's key counts.
      kr = 22'($urandom);
      rand_msg();
      make_rom(kr);
      pulse_start(kr, 3);
      check_done("held_start", cyc);
      chk("held_start_valid_lit", 64'(valid), 64'd1);

      // Abort at a random point late in a run, then decrypt with the right key.
      kr = 22'($urandom);
      rand_msg();
      make_rom(kr);
      pulse_start(22'($urandom), 1);
      repeat ($urandom_range(1800, 2100)) @(posedge clk);
      pulse_start(kr, 1);
      check_done("mid_prga_start", cyc);
      chk("mid_prga_valid_lit", 64'(valid), 64'd1);

      // Asynchronous reset during PRGA byte 10.
      pulse_start(kr, 1);
      cyc = 0;
      while (n_wr < 10 && cyc < 2150) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("reach_byte10", 64'(n_wr), 64'd10);
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1 chk_zero("async_reset");
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      load_model(key_in);
      check_done("after_reset", cyc);
      for (int n = 0; n < 32; n++) chk("after_reset_dram", 64'(dram_img[n]), 64'(pt_b[n]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
